// File: rtl/pe_acc_drain.sv
// Signed accumulate-and-drain stage: sums gemm beats until last, emits one result per unary beat.
// Define PE_ACC_SAT_EN for saturating sums; otherwise sums wrap and overflow is only flagged.
module pe_acc_drain #(
    parameter int unsigned MUL_BW = 16,
    parameter int unsigned ACC_BW = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            gemm_uno,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [2*MUL_BW-1:0]   prod_i,
    input  logic [ACC_BW-1:0]     offset_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_BW-1:0]     acc_o,
    output logic                  ovf_o
);

    localparam int unsigned PROD_W = 2 * MUL_BW;
    localparam int unsigned SUM_W  = ACC_BW + 2;
    localparam logic [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_BW-1:0]   acc_q, acc_d;
    logic                flag_q, flag_d;
    logic [ACC_BW-1:0]   acc_o_d;
    logic                ovf_o_d;
    logic                out_valid_d;

    logic                accept_c;
    logic                close_c;
    logic [SUM_W-1:0]    base_c;
    logic [SUM_W-1:0]    prod_ext_c;
    logic [SUM_W-1:0]    off_ext_c;
    logic [SUM_W-1:0]    sum_c;
    logic                ovf_pos_c;
    logic                ovf_neg_c;
    logic                ovf_beat_c;
    logic [ACC_BW-1:0]   res_c;

    assign in_ready = (state_q != DRAIN);
    assign accept_c = in_valid & in_ready;
    assign close_c  = accept_c & ((gemm_uno != 2'b00) | in_last);

    // Two guard bits make the three-operand sum exact; overflow shows as unequal top bits.
    assign base_c     = (state_q == ACC) ? {{2{acc_q[ACC_BW-1]}}, acc_q} : '0;
    assign prod_ext_c = {{(SUM_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};
    assign off_ext_c  = {{2{offset_i[ACC_BW-1]}}, offset_i};
    assign sum_c      = base_c + prod_ext_c + off_ext_c;
    assign ovf_pos_c  = ~sum_c[SUM_W-1] & (|sum_c[SUM_W-2:ACC_BW-1]);
    assign ovf_neg_c  = sum_c[SUM_W-1] & ~(&sum_c[SUM_W-2:ACC_BW-1]);
    assign ovf_beat_c = ovf_pos_c | ovf_neg_c;

`ifdef PE_ACC_SAT_EN
    assign res_c = ovf_pos_c ? ACC_MAX : (ovf_neg_c ? ACC_MIN : sum_c[ACC_BW-1:0]);
`else
    assign res_c = sum_c[ACC_BW-1:0];
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACC: begin
                if (close_c) begin
                    state_d = DRAIN;
                end else if (accept_c) begin
                    state_d = ACC;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Accumulator, burst flag and held-result updates
    always_comb begin
        acc_d       = acc_q;
        flag_d      = flag_q;
        acc_o_d     = acc_o;
        ovf_o_d     = ovf_o;
        out_valid_d = out_valid;
        if (close_c) begin
            acc_o_d     = res_c;
            ovf_o_d     = ((state_q == ACC) & flag_q) | ovf_beat_c;
            out_valid_d = 1'b1;
            acc_d       = '0;
            flag_d      = 1'b0;
        end else if (accept_c) begin
            acc_d  = res_c;
            flag_d = ((state_q == ACC) & flag_q) | ovf_beat_c;
        end else if ((state_q == DRAIN) && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            flag_q    <= 1'b0;
            acc_o     <= '0;
            ovf_o     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            flag_q    <= flag_d;
            acc_o     <= acc_o_d;
            ovf_o     <= ovf_o_d;
            out_valid <= out_valid_d;
        end
    end

endmodule
